// File: rtl/frame_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_packer_if
// Brief    : Pixel strobe input and packed-word valid/ready output bundle.
// Revision : 1.0  initial release
// ============================================================================
interface frame_packer_if;
    logic        pix_valid;
    logic [13:0] pix_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    // master is the packer; slave is the pixel source / word consumer
    modport master (
        input  pix_valid, pix_data, out_ready,
        output out_valid, out_data, out_last
    );
    modport slave (
        output pix_valid, pix_data, out_ready,
        input  out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : frame_packer
// Brief    : Packs 14-bit pixels two per 32-bit word, frames them with a
//            header and trailer, and buffers them in a FWFT output FIFO.
// Revision : 1.0  initial release
// ============================================================================
module frame_packer #(
    parameter int          PIXELS_PER_FRAME = 5184,
    parameter int          FIFO_DEPTH       = 16,
    parameter logic [15:0] HDR_TAG          = 16'hA5A5,
    parameter logic [15:0] TRL_TAG          = 16'h5A5A
) (
    input  logic                         ad_fco_clk,
    input  logic                         reset_n,
    frame_packer_if.master               bus,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         overflow,
    output logic [15:0]                  frame_cnt
);
    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0] LAST_PIX   = 16'(PIXELS_PER_FRAME);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAIR_LO = 2'd1,
        PAIR_HI = 2'd2,
        TRL     = 2'd3
    } state_t;

    state_t        state;
    logic [13:0]   pix_lo;
    logic [15:0]   pix_cnt;
    logic [15:0]   drop_cnt;

    logic          wr_req;
    logic          wr_last;
    logic [31:0]   wr_data;
    logic          push;
    logic          pop;
    logic          drop;

    logic [32:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   held_data;

    // The word is written on the same edge that samples the pixel strobe.
    always_comb begin
        wr_req  = 1'b0;
        wr_last = 1'b0;
        wr_data = '0;
        case (state)
            IDLE: begin
                if (bus.pix_valid) begin
                    wr_req  = 1'b1;
                    wr_data = {HDR_TAG, frame_cnt};
                end
            end
            PAIR_HI: begin
                if (bus.pix_valid) begin
                    wr_req  = 1'b1;
                    wr_data = {2'b00, pix_lo, 2'b00, bus.pix_data};
                end
            end
            TRL: begin
                wr_req  = 1'b1;
                wr_last = 1'b1;
                wr_data = {TRL_TAG, drop_cnt};
            end
            default: ;
        endcase
    end

    // A full FIFO drops the write even when a pop frees a slot this cycle.
    assign drop          = wr_req && (fifo_level == FULL_LEVEL);
    assign push          = wr_req && (fifo_level != FULL_LEVEL);
    assign bus.out_valid = (fifo_level != '0);
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.out_data  = bus.out_valid ? mem[rd_ptr][31:0] : held_data;
    assign bus.out_last  = bus.out_valid & mem[rd_ptr][32];

    always_ff @(posedge ad_fco_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pix_lo    <= '0;
            pix_cnt   <= '0;
            drop_cnt  <= '0;
            frame_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
            case (state)
                IDLE: begin
                    if (bus.pix_valid) begin
                        pix_lo   <= bus.pix_data;
                        pix_cnt  <= 16'd1;
                        // a dropped header counts against the fresh frame
                        drop_cnt <= {15'd0, drop};
                        state    <= PAIR_HI;
                    end
                end
                PAIR_LO: begin
                    if (bus.pix_valid) begin
                        pix_lo  <= bus.pix_data;
                        pix_cnt <= pix_cnt + 16'd1;
                        state   <= PAIR_HI;
                    end
                end
                PAIR_HI: begin
                    if (bus.pix_valid) begin
                        pix_cnt <= pix_cnt + 16'd1;
                        state   <= ((pix_cnt + 16'd1) == LAST_PIX) ? TRL : PAIR_LO;
                    end
                end
                TRL: begin
                    frame_cnt <= frame_cnt + 16'd1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge ad_fco_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            held_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                held_data <= mem[rd_ptr][31:0];
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
                2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge ad_fco_clk) begin
        if (push) begin
            mem[wr_ptr] <= {wr_last, wr_data};
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_packer
// Brief    : Directed scoreboard bench for frame_packer on three configurations.
// Revision : 1.0  initial release
// ============================================================================
module tb_frame_packer;
    localparam int N = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    frame_packer_if bus_a ();
    frame_packer_if bus_b ();
    frame_packer_if bus_c ();

    logic [4:0]  level_a;
    logic [2:0]  level_b;
    logic [2:0]  level_c;
    logic        ovf_a, ovf_b, ovf_c;
    logic [15:0] fcnt_a, fcnt_b, fcnt_c;

    frame_packer #(.PIXELS_PER_FRAME(4), .FIFO_DEPTH(16)) dut_a (
        .ad_fco_clk(clk), .reset_n(reset_n), .bus(bus_a),
        .fifo_level(level_a), .overflow(ovf_a), .frame_cnt(fcnt_a));
    frame_packer #(.PIXELS_PER_FRAME(8), .FIFO_DEPTH(4)) dut_b (
        .ad_fco_clk(clk), .reset_n(reset_n), .bus(bus_b),
        .fifo_level(level_b), .overflow(ovf_b), .frame_cnt(fcnt_b));
    frame_packer #(.PIXELS_PER_FRAME(2), .FIFO_DEPTH(4)) dut_c (
        .ad_fco_clk(clk), .reset_n(reset_n), .bus(bus_c),
        .fifo_level(level_c), .overflow(ovf_c), .frame_cnt(fcnt_c));

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_a [$];
    logic [32:0] exp_b [$];
    logic [32:0] exp_c [$];

    // Reference model state per DUT: pixel position, pending low pixel,
    // frame number, drop count and expected FIFO occupancy.
    int          m_cnt   [N];
    int          m_lvl   [N];
    int          m_ppf   [N] = '{4, 8, 2};
    int          m_depth [N] = '{16, 4, 4};
    logic [13:0] m_lo    [N];
    logic [15:0] m_frm   [N];
    logic [15:0] m_drop  [N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_pix(input int w, input logic v, input logic [13:0] d);
        case (w)
            0:       begin bus_a.pix_valid = v; bus_a.pix_data = d; end
            1:       begin bus_b.pix_valid = v; bus_b.pix_data = d; end
            default: begin bus_c.pix_valid = v; bus_c.pix_data = d; end
        endcase
    endtask

    task automatic model_write(input int w, input logic [32:0] word, input logic hdr);
        if (hdr) m_drop[w] = 16'h0;
        if (m_lvl[w] < m_depth[w]) begin
            m_lvl[w]++;
            case (w)
                0:       exp_a.push_back(word);
                1:       exp_b.push_back(word);
                default: exp_c.push_back(word);
            endcase
        end else if (m_drop[w] != 16'hFFFF) begin
            m_drop[w]++;
        end
    endtask

    // Present one pixel for one cycle; returns just after the sampling edge.
    task automatic drive(input int w, input logic [13:0] d);
        set_pix(w, 1'b1, d);
        if (m_cnt[w] == 0) model_write(w, {1'b0, 16'hA5A5, m_frm[w]}, 1'b1);
        if (m_cnt[w] % 2 == 0) m_lo[w] = d;
        else model_write(w, {1'b0, 2'b00, m_lo[w], 2'b00, d}, 1'b0);
        m_cnt[w]++;
        tick(1);
        set_pix(w, 1'b0, 14'h0);
        if (m_cnt[w] == m_ppf[w]) begin
            model_write(w, {1'b1, 16'h5A5A, m_drop[w]}, 1'b0);
            m_frm[w] = m_frm[w] + 16'd1;
            m_cnt[w] = 0;
        end
    endtask

    task automatic send(input int w, input logic [13:0] d);
        drive(w, d);
        tick(1);
    endtask

    task automatic pop_check(input int w, input logic [32:0] got);
        logic [32:0] want;
        int          sz;
        case (w)
            0:       sz = exp_a.size();
            1:       sz = exp_b.size();
            default: sz = exp_c.size();
        endcase
        m_lvl[w]--;
        if (sz == 0) begin
            checks++;
            errors++;
            $error("FAIL word_%0d: observed %0h expected no word", w, got);
        end else begin
            case (w)
                0:       want = exp_a.pop_front();
                1:       want = exp_b.pop_front();
                default: want = exp_c.pop_front();
            endcase
            check($sformatf("word_%0d", w), 64'(got), 64'(want));
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus_a.out_valid && bus_a.out_ready) pop_check(0, {bus_a.out_last, bus_a.out_data});
            if (bus_b.out_valid && bus_b.out_ready) pop_check(1, {bus_b.out_last, bus_b.out_data});
            if (bus_c.out_valid && bus_c.out_ready) pop_check(2, {bus_c.out_last, bus_c.out_data});
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        exp_a.delete();
        exp_b.delete();
        exp_c.delete();
        for (int i = 0; i < N; i++) begin
            m_cnt[i]  = 0;
            m_lvl[i]  = 0;
            m_lo[i]   = '0;
            m_frm[i]  = '0;
            m_drop[i] = '0;
        end
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic drain();
        int i = 0;
        while ((exp_a.size() + exp_b.size() + exp_c.size()) != 0 && i < 100) begin
            tick(1);
            i++;
        end
        check("drain_queues", 64'(exp_a.size() + exp_b.size() + exp_c.size()), 64'd0);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: time %0t reached, required finish before 4000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        set_pix(0, 1'b0, 14'h0);
        set_pix(1, 1'b0, 14'h0);
        set_pix(2, 1'b0, 14'h0);
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        bus_c.out_ready = 1'b1;
        do_reset();

        // Reset state
        check("rst_valid", 64'(bus_a.out_valid), 64'd0);
        check("rst_last",  64'(bus_a.out_last),  64'd0);
        check("rst_data",  64'(bus_a.out_data),  64'd0);
        check("rst_level", 64'(level_a), 64'd0);
        check("rst_ovf",   64'(ovf_a),   64'd0);
        check("rst_fcnt",  64'(fcnt_a),  64'd0);

        // Test 1: pixels 1..4, header visible one cycle after the first pixel
        drive(0, 14'd1);
        check("lat_valid", 64'(bus_a.out_valid), 64'd1);
        check("lat_data",  64'(bus_a.out_data),  64'hA5A5_0000);
        tick(1);
        send(0, 14'd2);
        send(0, 14'd3);
        send(0, 14'd4);
        drain();
        check("t1_fcnt",       64'(fcnt_a), 64'd1);
        check("t1_empty_last", 64'(bus_a.out_last), 64'd0);
        check("t1_hold_data",  64'(bus_a.out_data), 64'h5A5A_0000);

        // Test 2: extreme and alternating pixel values
        send(0, 14'h3FFF);
        send(0, 14'h0000);
        send(0, 14'h2AAA);
        send(0, 14'h1555);
        drain();
        check("t2_fcnt", 64'(fcnt_a), 64'd2);
        check("t2_hold", 64'(bus_a.out_data), 64'h5A5A_0000);

        // Test 3: 8-pixel frame into a 4-deep FIFO with the consumer stalled
        bus_b.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(1, 14'(i + 16));
        check("t3_level", 64'(level_b), 64'd4);
        check("t3_ovf",   64'(ovf_b),   64'd1);
        check("t3_fcnt",  64'(fcnt_b),  64'd1);
        bus_b.out_ready = 1'b1;
        drain();
        for (int i = 0; i < 8; i++) send(1, 14'(i + 100));
        drain();
        check("t3_level_end", 64'(level_b), 64'd0);

        // Test 4: write at full level with a pop on the same edge
        do_reset();
        bus_b.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) send(1, 14'(i + 200));
        check("t4_full", 64'(level_b), 64'd4);
        check("t4_ovf_before", 64'(ovf_b), 64'd0);
        bus_b.out_ready = 1'b1;
        drive(1, 14'd207);
        check("t4_level", 64'(level_b), 64'd3);
        check("t4_ovf",   64'(ovf_b),   64'd1);
        tick(1);
        drain();

        // Test 5: reset in mid-frame flushes the FIFO
        bus_a.out_ready = 1'b0;
        send(0, 14'd11);
        send(0, 14'd12);
        send(0, 14'd13);
        check("t5_level_pre", 64'(level_a), 64'd2);
        do_reset();
        check("t5_level", 64'(level_a), 64'd0);
        check("t5_valid", 64'(bus_a.out_valid), 64'd0);
        check("t5_data",  64'(bus_a.out_data),  64'd0);
        bus_a.out_ready = 1'b1;
        send(0, 14'd21);
        send(0, 14'd22);
        send(0, 14'd23);
        send(0, 14'd24);
        drain();
        check("t5_fcnt", 64'(fcnt_a), 64'd1);

        // Test 6: frame counter wraps through FFFF in the header count
        for (int f = 0; f < 65538; f++) begin
            send(2, 14'(f));
            send(2, 14'(~f));
            if (f == 65535) check("t6_fcnt_wrap", 64'(fcnt_c), 64'd0);
        end
        drain();
        check("t6_fcnt_end", 64'(fcnt_c), 64'd2);
        check("t6_level",    64'(level_c), 64'd0);
        check("t6_ovf",      64'(ovf_c), 64'd0);
        check("end_ovf_a",   64'(ovf_a), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
